kgp_trace_capture: RTL and testbench

//  Consumes the KGP_RISC core's retire-trace outputs (pc, new_pc, instruction, aluresult) and records
//  one 3-word record per executed instruction into an on-chip FIFO. A valid/ready stream drains the

---
 rtl/kgp_trace_capture_pkg.sv | 44 ++++
 rtl/kgp_trace_capture_if.sv | 12 +
 rtl/kgp_trace_fifo.sv | 65 ++++++
 rtl/kgp_trace_capture.sv | 140 ++++++++++++++
 tb/tb_kgp_trace_capture.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kgp_trace_capture_pkg.sv
// Shared definitions for the KGP_RISC retire-trace capture block: record layout,
// stream word-index encoding and a helper that picks one word out of a record.
package kgp_trace_capture_pkg;

  localparam int REC_W     = 96;
  localparam int WORD_W    = 32;
  localparam int PC_LSB    = 64;
  localparam int INSTR_LSB = 32;
  localparam int ALU_LSB   = 0;

  localparam logic [31:0] PC_RESET = 32'hFFFF_FFFF;

  // Which word of the head record the stream is presenting.
  typedef enum logic [1:0] {
    W_PC    = 2'd0,
    W_INSTR = 2'd1,
    W_ALU   = 2'd2
  } word_e;

  // Select the 32-bit stream word of a packed record for a given word index.
  function automatic logic [WORD_W-1:0] rec_word(input logic [REC_W-1:0] rec, input word_e idx);
    logic [WORD_W-1:0] w;
    case (idx)
      W_PC:    w = rec[PC_LSB    +: WORD_W];
      W_INSTR: w = rec[INSTR_LSB +: WORD_W];
      W_ALU:   w = rec[ALU_LSB   +: WORD_W];
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Pack the three trace fields into one record.
  function automatic logic [REC_W-1:0] rec_pack(input logic [WORD_W-1:0] pc,
                                                input logic [WORD_W-1:0] instr,
                                                input logic [WORD_W-1:0] alu);
    logic [REC_W-1:0] r;
    r = {REC_W{1'b0}};
    r[PC_LSB    +: WORD_W] = pc;
    r[INSTR_LSB +: WORD_W] = instr;
    r[ALU_LSB   +: WORD_W] = alu;
    return r;
  endfunction

endpackage

// File: rtl/kgp_trace_capture_if.sv
// Valid/ready word stream carrying trace records out of the capture block.
interface kgp_trace_capture_if;
  import kgp_trace_capture_pkg::*;

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/kgp_trace_fifo.sv
// Synchronous record FIFO with an occupancy count that can represent 0..DEPTH.
// A push while full is accepted only if a pop happens in the same cycle.
module kgp_trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (cnt == {(AW+1){1'b0}});
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  // Qualify requests: pop needs data, push needs room or a simultaneous pop.
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      cnt    <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Record storage; contents are only visible through the head while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/kgp_trace_capture.sv
// Retire-trace capture: records {pc, instruction, aluresult} once per new PC into a
// FIFO and streams each record out as three words (pc, instruction, aluresult).
module kgp_trace_capture
  import kgp_trace_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic [31:0]              pc,
  input  logic [31:0]              new_pc,
  input  logic [31:0]              instruction,
  input  logic [31:0]              aluresult,
  kgp_trace_capture_if.master      strm,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic                     halt_seen
);

  logic [31:0]      prev_pc;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             hs;
  logic             drop;
  logic [REC_W-1:0] head;
  word_e            idx;
  word_e            idx_next;
  logic [31:0]      data_c;
  logic             valid_c;
  logic             last_c;

  kgp_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (rec_pack(pc, instruction, aluresult)),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Capture request, handshake, pop and drop decode.
  always_comb begin
    push = cap_en & (pc != prev_pc);
    hs   = ~empty & strm.out_ready;
    pop  = hs & (idx == W_ALU);
    drop = push & full & ~pop;
  end

  // Track the previous PC every cycle so a stalled PC yields a single record.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_pc <= PC_RESET;
    end else begin
      prev_pc <= pc;
    end
  end

  // Saturating dropped-record counter and sticky self-loop flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_cnt <= {CNT_W{1'b0}};
      halt_seen    <= 1'b0;
    end else begin
      if (drop && (overflow_cnt != {CNT_W{1'b1}})) begin
        overflow_cnt <= overflow_cnt + CNT_W'(1);
      end else begin
        overflow_cnt <= overflow_cnt;
      end
      if (push && (new_pc == pc)) begin
        halt_seen <= 1'b1;
      end else begin
        halt_seen <= halt_seen;
      end
    end
  end

  // Word-index state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= W_PC;
    end else begin
      idx <= idx_next;
    end
  end

  // Word-index next state: advance one word per accepted handshake.
  always_comb begin
    idx_next = idx;
    if (empty) begin
      idx_next = W_PC;
    end else begin
      case (idx)
        W_PC: begin
          if (hs) idx_next = W_INSTR;
          else    idx_next = W_PC;
        end
        W_INSTR: begin
          if (hs) idx_next = W_ALU;
          else    idx_next = W_INSTR;
        end
        W_ALU: begin
          if (hs) idx_next = W_PC;
          else    idx_next = W_ALU;
        end
        default: idx_next = W_PC;
      endcase
    end
  end

  // Stream outputs: the head record word selected by the index, zero when empty.
  always_comb begin
    valid_c = 1'b0;
    last_c  = 1'b0;
    data_c  = 32'd0;
    if (!empty) begin
      valid_c = 1'b1;
      last_c  = (idx == W_ALU);
      data_c  = rec_word(head, idx);
    end else begin
      valid_c = 1'b0;
      last_c  = 1'b0;
      data_c  = 32'd0;
    end
  end

  assign strm.out_data  = data_c;
  assign strm.out_valid = valid_c;
  assign strm.out_last  = last_c;

endmodule

// File: tb/tb_kgp_trace_capture.sv
// Directed self-checking bench for kgp_trace_capture.
module tb_kgp_trace_capture;

  logic        clk;
  logic        rst;
  logic        cap_en;
  logic [31:0] pc;
  logic [31:0] new_pc;
  logic [31:0] instruction;
  logic [31:0] aluresult;
  logic [4:0]  fifo_count;
  logic [15:0] overflow_cnt;
  logic        halt_seen;

  int n_checks;
  int n_fail;

  logic [31:0] got_q[$];
  bit          last_q[$];

  kgp_trace_capture_if bus();

  kgp_trace_capture #(.DEPTH(16), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cap_en       (cap_en),
    .pc           (pc),
    .new_pc       (new_pc),
    .instruction  (instruction),
    .aluresult    (aluresult),
    .strm         (bus),
    .fifo_count   (fifo_count),
    .overflow_cnt (overflow_cnt),
    .halt_seen    (halt_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted stream word, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      last_q.push_back(bus.out_last);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] np,
                       input logic [31:0] ins, input logic [31:0] alu);
    pc = p; new_pc = np; instruction = ins; aluresult = alu;
  endtask

  task automatic drain_wait();
    for (int b = 0; b < 200; b++) begin
      if (fifo_count == 5'd0) break;
      tick();
    end
    chk("drain_done", {59'd0, fifo_count}, 64'd0);
  endtask

  initial begin
    int lasts;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; cap_en = 1'b0; bus.out_ready = 1'b0;
    drive(32'h0, 32'h4, 32'h0, 32'h0);

    // 1 Reset with pc toggling
    for (int i = 0; i < 2; i++) begin
      drive(32'h100 + 32'(i) * 32'd4, 32'h104 + 32'(i) * 32'd4, 32'h0, 32'h0);
      tick();
    end
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_count", {59'd0, fifo_count}, 64'd0);
    chk("rst_ovf",   {48'd0, overflow_cnt}, 64'd0);
    chk("rst_halt",  {63'd0, halt_seen}, 64'd0);
    chk("rst_data",  {32'd0, bus.out_data}, 64'd0);
    chk("rst_last",  {63'd0, bus.out_last}, 64'd0);

    // 2 Basic three-record stream with consumer always ready
    rst = 1'b1; cap_en = 1'b1; bus.out_ready = 1'b1;
    got_q.delete(); last_q.delete();
    drive(32'h0, 32'h4, 32'hA, 32'h1);
    tick();
    chk("lat_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("lat_data",  {32'd0, bus.out_data}, 64'd0);
    drive(32'h4, 32'h8, 32'hB, 32'h2);
    tick();
    drive(32'h8, 32'hC, 32'hC, 32'h3);
    tick();
    cap_en = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("basic_n", 64'(got_q.size()), 64'd9);
    if (got_q.size() == 9) begin
      chk("basic_w0", {32'd0, got_q[0]}, 64'h0);
      chk("basic_w1", {32'd0, got_q[1]}, 64'hA);
      chk("basic_w2", {32'd0, got_q[2]}, 64'h1);
      chk("basic_w3", {32'd0, got_q[3]}, 64'h4);
      chk("basic_w4", {32'd0, got_q[4]}, 64'hB);
      chk("basic_w5", {32'd0, got_q[5]}, 64'h2);
      chk("basic_w6", {32'd0, got_q[6]}, 64'h8);
      chk("basic_w7", {32'd0, got_q[7]}, 64'hC);
      chk("basic_w8", {32'd0, got_q[8]}, 64'h3);
      lasts = 0;
      for (int i = 0; i < 9; i++) begin
        if (last_q[i]) lasts++;
        chk("basic_last_pos", {63'd0, last_q[i]}, ((i % 3) == 2) ? 64'd1 : 64'd0);
      end
      chk("basic_last_n", 64'(lasts), 64'd3);
    end
    chk("basic_empty", {59'd0, fifo_count}, 64'd0);

    // 3 Overflow: 20 records into a 16-deep FIFO, then drain in order
    bus.out_ready = 1'b0; cap_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(32'h1000 + 32'(i) * 32'd4, 32'h1004 + 32'(i) * 32'd4,
            32'h100 + 32'(i), 32'h200 + 32'(i));
      tick();
    end
    cap_en = 1'b0;
    tick();
    chk("ovf_count", {59'd0, fifo_count}, 64'd16);
    chk("ovf_cnt",   {48'd0, overflow_cnt}, 64'd4);
    chk("ovf_head",  {32'd0, bus.out_data}, 64'h1000);
    tick(); tick();
    chk("stall_data", {32'd0, bus.out_data}, 64'h1000);
    chk("stall_last", {63'd0, bus.out_last}, 64'd0);
    got_q.delete(); last_q.delete();
    bus.out_ready = 1'b1;
    drain_wait();
    tick();
    chk("ovf_words", 64'(got_q.size()), 64'd48);
    if (got_q.size() == 48) begin
      for (int r = 0; r < 16; r++) begin
        chk("ovf_pc",    {32'd0, got_q[3*r]},   64'(32'h1000 + 32'(r) * 32'd4));
        chk("ovf_instr", {32'd0, got_q[3*r+1]}, 64'(32'h100 + 32'(r)));
        chk("ovf_alu",   {32'd0, got_q[3*r+2]}, 64'(32'h200 + 32'(r)));
        chk("ovf_last",  {63'd0, last_q[3*r+2]}, 64'd1);
      end
    end
    chk("ovf_valid_end", {63'd0, bus.out_valid}, 64'd0);
    chk("ovf_data_end",  {32'd0, bus.out_data}, 64'd0);

    // 4 PC stall with self-loop
    bus.out_ready = 1'b0; cap_en = 1'b1;
    chk("halt_pre", {63'd0, halt_seen}, 64'd0);
    drive(32'h40, 32'h40, 32'h44, 32'h55);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_one", {59'd0, fifo_count}, 64'd1);
    chk("halt_set",  {63'd0, halt_seen}, 64'd1);
    cap_en = 1'b0;
    drive(32'h50, 32'h54, 32'h0, 32'h0);
    tick();
    chk("halt_sticky", {63'd0, halt_seen}, 64'd1);
    chk("capoff_cnt",  {59'd0, fifo_count}, 64'd1);
    got_q.delete(); last_q.delete();
    bus.out_ready = 1'b1;
    drain_wait();
    chk("stall_words", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("stall_pc",  {32'd0, got_q[0]}, 64'h40);
      chk("stall_ins", {32'd0, got_q[1]}, 64'h44);
      chk("stall_alu", {32'd0, got_q[2]}, 64'h55);
    end

    // 5 Full FIFO with push and pop in the same cycle
    bus.out_ready = 1'b0; cap_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(32'h2000 + 32'(i) * 32'd4, 32'h2004 + 32'(i) * 32'd4, 32'h0, 32'h0);
      tick();
    end
    cap_en = 1'b0;
    chk("full_count", {59'd0, fifo_count}, 64'd16);
    got_q.delete(); last_q.delete();
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("full_at_alu", {63'd0, bus.out_last}, 64'd1);
    cap_en = 1'b1;
    drive(32'h3000, 32'h3004, 32'h3333, 32'h4444);
    tick();
    bus.out_ready = 1'b0; cap_en = 1'b0;
    chk("simul_count", {59'd0, fifo_count}, 64'd16);
    chk("simul_ovf",   {48'd0, overflow_cnt}, 64'd4);
    chk("simul_head",  {32'd0, bus.out_data}, 64'h2004);
    for (int i = 0; i < 3; i++) begin
      drive(32'h7000 + 32'(i) * 32'd4, 32'h7004 + 32'(i) * 32'd4, 32'h0, 32'h0);
      tick();
    end
    chk("capoff_full", {59'd0, fifo_count}, 64'd16);
    chk("capoff_ovf",  {48'd0, overflow_cnt}, 64'd4);
    cap_en = 1'b1;
    drive(32'h7100, 32'h7104, 32'h0, 32'h0);
    tick();
    cap_en = 1'b0;
    chk("drop_ovf", {48'd0, overflow_cnt}, 64'd5);
    got_q.delete(); last_q.delete();
    bus.out_ready = 1'b1;
    drain_wait();
    chk("full_words", 64'(got_q.size()), 64'd48);
    if (got_q.size() == 48) begin
      chk("full_first", {32'd0, got_q[0]},  64'h2004);
      chk("full_lastpc", {32'd0, got_q[45]}, 64'h3000);
      chk("full_lastin", {32'd0, got_q[46]}, 64'h3333);
      chk("full_lastal", {32'd0, got_q[47]}, 64'h4444);
    end

    // 6 Reset in the middle of a record
    bus.out_ready = 1'b0; cap_en = 1'b1;
    drive(32'h5000, 32'h5004, 32'h5100, 32'h5200);
    tick();
    drive(32'h5004, 32'h5008, 32'h5101, 32'h5201);
    tick();
    cap_en = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("mid_instr", {32'd0, bus.out_data}, 64'h5100);
    rst = 1'b0;
    tick();
    chk("mid_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_count", {59'd0, fifo_count}, 64'd0);
    chk("mid_data",  {32'd0, bus.out_data}, 64'd0);
    chk("mid_ovf",   {48'd0, overflow_cnt}, 64'd0);
    chk("mid_halt",  {63'd0, halt_seen}, 64'd0);
    rst = 1'b1; cap_en = 1'b1;
    drive(32'h6000, 32'h6004, 32'h6100, 32'h6200);
    tick();
    cap_en = 1'b0;
    chk("post_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("post_pc",    {32'd0, bus.out_data}, 64'h6000);
    chk("post_count", {59'd0, fifo_count}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
